// File: rtl/avr_fetch_q_if.sv
// avr_fetch_q_if -- bus between the prefetch queue, program memory and the CPU.
//
// Parameters: PC_W (word-address width), DEPTH (queue entries).
// Signals:
//   prog_addr   fetch word address to program memory
//   prog_data   program word read combinationally at prog_addr
//   pc_src      redirect select (0 seq, 1 relative, 2 absolute, 3 skip, 4-7 seq)
//   jmp         redirect operand (signed offset / absolute target)
//   consume     CPU accepts the head instruction this cycle
//   cur_instr   head instruction word (0x0000 when empty)
//   cur_op2     second word of a two-word head instruction, else 0
//   cur_pc      word address of cur_instr
//   instr_valid head instruction complete and consumable
//   q_count     occupied entries
// Modports: master = fetch unit, slave = memory/CPU side.
interface avr_fetch_q_if #(
   parameter int PC_W  = 16,
   parameter int DEPTH = 4
);
   logic [PC_W-1:0]        prog_addr;
   logic [15:0]            prog_data;
   logic [2:0]             pc_src;
   logic [15:0]            jmp;
   logic                   consume;
   logic [15:0]            cur_instr;
   logic [15:0]            cur_op2;
   logic [PC_W-1:0]        cur_pc;
   logic                   instr_valid;
   logic [$clog2(DEPTH):0] q_count;

   modport master (
      output prog_addr, cur_instr, cur_op2, cur_pc, instr_valid, q_count,
      input  prog_data, pc_src, jmp, consume
   );

   modport slave (
      input  prog_addr, cur_instr, cur_op2, cur_pc, instr_valid, q_count,
      output prog_data, pc_src, jmp, consume
   );
endinterface

// File: rtl/avr_fetch_q.sv
// avr_fetch_q -- instruction prefetch queue between program memory and avr_cpu.
//
// Runs ahead through sequential program words, buffering {pc, word} entries in
// a circular queue. Handles absolute/relative redirects (queue flush plus one
// FLUSH bubble cycle) and skip-next.
//
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset
//   bus  avr_fetch_q_if.master (program memory fetch + CPU head interface)
//
// Optional feature macro: AVR_FETCH_WIDE_EN -- decode two-word opcodes
// (JMP/CALL/LDS/STS) and present them as one instruction with cur_op2.
// Without it every word is a one-word instruction and cur_op2 is 0.
module avr_fetch_q #(
   parameter int PC_W  = 16,
   parameter int DEPTH = 4
) (
   input logic           CLK,
   input logic           RST,
   avr_fetch_q_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_FILL, S_FULL, S_FLUSH} fstate_t;

   fstate_t         state_q, state_n;
   logic [PC_W-1:0] mem_pc   [DEPTH];
   logic [15:0]     mem_word [DEPTH];
   logic [PC_W-1:0] fpc_q, fpc_n, target;
   logic [PW-1:0]   rd_q, rd_n, wr_q, wr_n;
   logic [CW-1:0]   count_q, count_n, hw, nw, pop_n;
   logic            skip_pend, skip_pend_n;  // drop the next enqueued instruction
   logic            skip_w2, skip_w2_n;      // drop the next enqueued word (2nd half)
   logic            head_two, nxt_two, in_two;
   logic            valid, pop, rel_go, abs_go, redirect, skip_go;
   logic            new_pi, new_pw, pi_eff, pw_eff, en_try, wr_en;

`ifdef AVR_FETCH_WIDE_EN
   function automatic logic is_two(input logic [15:0] w);
      return (w[15:9] == 7'b1001010 && w[3:2] == 2'b11) ||   // JMP / CALL
             (w[15:10] == 6'b100100 && w[3:0] == 4'b0000);   // LDS / STS
   endfunction
`endif

   always_comb begin
      head_two = 1'b0;
      nxt_two  = 1'b0;
      in_two   = 1'b0;
`ifdef AVR_FETCH_WIDE_EN
      head_two = (count_q != '0) && is_two(mem_word[rd_q]);
      nxt_two  = is_two(mem_word[head_two ? rd_q + PW'(2) : rd_q + PW'(1)]);
      in_two   = is_two(bus.prog_data);
`endif
      hw = head_two ? CW'(2) : CW'(1);
      nw = nxt_two ? CW'(2) : CW'(1);

      valid    = (count_q >= hw);
      pop      = bus.consume && valid;
      rel_go   = (bus.pc_src == 3'd1) && pop;
      abs_go   = (bus.pc_src == 3'd2);
      redirect = rel_go || abs_go;
      skip_go  = (bus.pc_src == 3'd3) && pop;

      if (abs_go)
         target = PC_W'(bus.jmp);
      else
         target = bus.cur_pc + (head_two ? PC_W'(2) : PC_W'(1)) + PC_W'(signed'(bus.jmp));

      // Skip: discard as much of the following instruction as is queued now;
      // whatever is not yet queued is dropped at enqueue time instead.
      pop_n  = pop ? hw : '0;
      new_pi = 1'b0;
      new_pw = 1'b0;
      if (skip_go) begin
         if (count_q >= hw + nw) begin
            pop_n = hw + nw;
         end else if (count_q > hw) begin
            pop_n  = hw + CW'(1);
            new_pw = 1'b1;
         end else begin
            new_pi = 1'b1;
         end
      end

      en_try = !redirect && (state_q != S_FLUSH) && ((state_q != S_FULL) || (pop_n != '0));
      pi_eff = skip_pend || new_pi;
      pw_eff = skip_w2 || new_pw;

      wr_en       = 1'b0;
      skip_pend_n = pi_eff;
      skip_w2_n   = pw_eff;
      if (en_try) begin
         if (pw_eff) begin
            skip_w2_n = 1'b0;
         end else if (pi_eff) begin
            // Dropped word is the first word of the skipped instruction;
            // a two-word opcode also takes the following word with it.
            skip_pend_n = 1'b0;
            skip_w2_n   = in_two;
         end else begin
            wr_en = 1'b1;
         end
      end

      fpc_n   = en_try ? fpc_q + PC_W'(1) : fpc_q;
      rd_n    = rd_q + pop_n[PW-1:0];
      wr_n    = wr_en ? wr_q + PW'(1) : wr_q;
      count_n = count_q - pop_n + CW'(wr_en);

      if (redirect) begin
         fpc_n       = target;
         rd_n        = '0;
         wr_n        = '0;
         count_n     = '0;
         skip_pend_n = 1'b0;
         skip_w2_n   = 1'b0;
         state_n     = S_FLUSH;
      end else if (count_n == CW'(DEPTH)) begin
         state_n = S_FULL;
      end else begin
         state_n = S_FILL;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_FILL;
         fpc_q     <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         count_q   <= '0;
         skip_pend <= 1'b0;
         skip_w2   <= 1'b0;
      end else begin
         state_q   <= state_n;
         fpc_q     <= fpc_n;
         rd_q      <= rd_n;
         wr_q      <= wr_n;
         count_q   <= count_n;
         skip_pend <= skip_pend_n;
         skip_w2   <= skip_w2_n;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en && !RST) begin
         mem_pc[wr_q]   <= fpc_q;
         mem_word[wr_q] <= bus.prog_data;
      end
   end

   always_comb begin
      bus.prog_addr   = fpc_q;
      bus.q_count     = count_q;
      bus.instr_valid = valid;
      bus.cur_instr   = (count_q != '0) ? mem_word[rd_q] : '0;
      bus.cur_pc      = (count_q != '0) ? mem_pc[rd_q] : '0;
      bus.cur_op2     = '0;
`ifdef AVR_FETCH_WIDE_EN
      if (head_two && count_q >= CW'(2))
         bus.cur_op2 = mem_word[rd_q + PW'(1)];
`endif
   end
endmodule

// File: tb/tb_avr_fetch_q.sv
// tb_avr_fetch_q -- directed bench for avr_fetch_q (PC_W=16, DEPTH=4).
// Expected head PCs are pushed to a scoreboard queue as the stream is planned
// and popped/compared each time the bench consumes a valid head.
// Two-word sections run only when AVR_FETCH_WIDE_EN is defined.
module tb_avr_fetch_q;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [15:0] prog [0:65535];
   logic [15:0] sb [$];

   avr_fetch_q_if #(.PC_W(16), .DEPTH(4)) bus ();

   avr_fetch_q #(.PC_W(16), .DEPTH(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   assign bus.prog_data = prog[bus.prog_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      bus.consume = 1'b0;
      bus.pc_src  = 3'd0;
      bus.jmp     = 16'h0000;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_run(input logic [15:0] start, input int n);
      for (int i = 0; i < n; i++) sb.push_back(start + 16'(i));
   endtask

   // Consume the head with the given redirect request; head is scored first.
   task automatic take(input logic [2:0] src, input logic [15:0] j);
      logic [15:0] e;
      bus.consume = 1'b1;
      bus.pc_src  = src;
      bus.jmp     = j;
      if (!bus.instr_valid) begin
         chk("take_valid", 32'(bus.instr_valid), 32'd1);
      end else if (sb.size() == 0) begin
         chk("sb_underflow", 32'(bus.cur_pc), 32'hFFFF_FFFF);
      end else begin
         e = sb.pop_front();
         chk("head_pc", 32'(bus.cur_pc), 32'(e));
         chk("head_instr", 32'(bus.cur_instr), 32'(prog[e]));
      end
      tick();
      bus.consume = 1'b0;
      bus.pc_src  = 3'd0;
      bus.jmp     = 16'h0000;
   endtask

   initial begin
      #200000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 65536; a++) prog[a] = 16'hE000 | (16'(a) & 16'h0FFF) ^ 16'h00A4;
      prog[1]  = 16'h50A1;
      prog[10] = 16'h940C;
      prog[11] = 16'h0200;
      bus.consume = 1'b0;
      bus.pc_src  = 3'd0;
      bus.jmp     = 16'h0000;

      // Reset and fill
      RST = 1'b1;
      tick();
      tick();
      chk("rst_prog_addr", 32'(bus.prog_addr), 32'd0);
      chk("rst_q_count", 32'(bus.q_count), 32'd0);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr", 32'(bus.cur_instr), 32'd0);
      chk("rst_op2", 32'(bus.cur_op2), 32'd0);
      chk("rst_pc", 32'(bus.cur_pc), 32'd0);
      RST = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("fill_prog_addr", 32'(bus.prog_addr), 32'(k));
         chk("fill_q_count", 32'(bus.q_count), 32'(k));
      end
      chk("fill_valid", 32'(bus.instr_valid), 32'd1);
      chk("fill_instr", 32'(bus.cur_instr), 32'h0000_E0A4);
      chk("fill_pc", 32'(bus.cur_pc), 32'd0);
      tick();
      chk("full_hold_addr", 32'(bus.prog_addr), 32'd4);
      chk("full_q_count", 32'(bus.q_count), 32'd4);

      // Streaming from full
      push_run(16'h0000, 4);
      for (int k = 0; k < 3; k++) begin
         take(3'd0, 16'h0000);
         chk("stream_q_count", 32'(bus.q_count), 32'd4);
      end

      // Absolute jump at cur_pc=3
      take(3'd2, 16'h0100);
      chk("abs_q_count", 32'(bus.q_count), 32'd0);
      chk("abs_prog_addr", 32'(bus.prog_addr), 32'h100);
      chk("abs_bubble_valid", 32'(bus.instr_valid), 32'd0);
      idle(1);
      chk("abs_flush_valid", 32'(bus.instr_valid), 32'd0);
      idle(1);
      chk("abs_valid", 32'(bus.instr_valid), 32'd1);
      chk("abs_pc", 32'(bus.cur_pc), 32'h100);

      // Relative jump with wrap from cur_pc=2
      push_run(16'h0100, 1);
      take(3'd2, 16'h0002);
      idle(2);
      chk("rel_setup_pc", 32'(bus.cur_pc), 32'd2);
      push_run(16'h0002, 1);
      take(3'd1, 16'hFFF0);
      idle(2);
      chk("rel_valid", 32'(bus.instr_valid), 32'd1);
      chk("rel_pc", 32'(bus.cur_pc), 32'hFFF3);

      // Stream through address wrap up to pc 4, then let the queue refill
      push_run(16'hFFF3, 18);
      for (int k = 0; k < 18; k++) take(3'd0, 16'h0000);
      idle(3);
      chk("refill_q_count", 32'(bus.q_count), 32'd4);

      // Skip with next instruction queued at cur_pc=5
      push_run(16'h0005, 1);
      take(3'd3, 16'h0000);
      chk("skip_q_pc", 32'(bus.cur_pc), 32'd7);
      chk("skip_q_count", 32'(bus.q_count), 32'd3);

      // Skip with nothing queued behind the head
      push_run(16'h0007, 1);
      take(3'd2, 16'h0040);
      idle(2);
      push_run(16'h0040, 1);
      take(3'd3, 16'h0000);
      chk("skip_e_valid", 32'(bus.instr_valid), 32'd0);
      chk("skip_e_q_count", 32'(bus.q_count), 32'd0);
      idle(1);
      chk("skip_e_valid2", 32'(bus.instr_valid), 32'd1);
      chk("skip_e_pc", 32'(bus.cur_pc), 32'h42);
      push_run(16'h0042, 4);
      for (int k = 0; k < 4; k++) take(3'd0, 16'h0000);

      // Reset mid-operation with competing inputs
      bus.consume = 1'b1;
      bus.pc_src  = 3'd2;
      bus.jmp     = 16'h1234;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      bus.consume = 1'b0;
      bus.pc_src  = 3'd0;
      bus.jmp     = 16'h0000;
      chk("mid_rst_q_count", 32'(bus.q_count), 32'd0);
      chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("mid_rst_addr", 32'(bus.prog_addr), 32'd0);
      tick();
      chk("mid_rst_refill_valid", 32'(bus.instr_valid), 32'd1);
      chk("mid_rst_refill_pc", 32'(bus.cur_pc), 32'd0);

`ifdef AVR_FETCH_WIDE_EN
      // Two-word JMP at word 10
      push_run(16'h0000, 1);
      take(3'd2, 16'h0009);
      idle(5);
      chk("wide_fill_q_count", 32'(bus.q_count), 32'd4);
      push_run(16'h0009, 1);
      take(3'd0, 16'h0000);
      chk("wide_valid", 32'(bus.instr_valid), 32'd1);
      chk("wide_instr", 32'(bus.cur_instr), 32'h940C);
      chk("wide_op2", 32'(bus.cur_op2), 32'h0200);
      push_run(16'h000A, 1);
      take(3'd0, 16'h0000);
      chk("wide_after_pc", 32'(bus.cur_pc), 32'd12);

      // Skip over the two-word instruction from word 9
      push_run(16'h000C, 1);
      take(3'd2, 16'h0009);
      idle(5);
      push_run(16'h0009, 1);
      take(3'd3, 16'h0000);
      chk("wide_skip_pc", 32'(bus.cur_pc), 32'd12);
      chk("wide_skip_op2", 32'(bus.cur_op2), 32'd0);
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/avr_fetch_q.md
# avr_fetch_q

Parametrised instruction-fetch unit for the AVR core. It replaces the single-word fetch stage with a prefetch queue between program memory and `avr_cpu`. The block runs ahead of the CPU through sequential program words and buffers them with their word addresses. It handles absolute jumps, relative jumps and skip redirects, and can optionally assemble two-word (32-bit) AVR instructions.

## Interface
Parameters:
- `PC_W`, 16: program-counter / word-address width.
- `DEPTH`, 4: queue entries; power of two, ≥ 2 (≥ 4 when `AVR_FETCH_WIDE_EN` is defined).

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `prog_addr`  out  PC_W  program-memory word address; driven from the fetch-PC register `fpc`.
- `prog_data`  in  16  program-memory word; combinational read of `prog_addr` in the same cycle.
- `pc_src`  in  3  redirect select: 0 = sequential, 1 = relative, 2 = absolute, 3 = skip next, 4–7 = sequential.
- `jmp`  in  16  redirect operand; signed offset for relative, target for absolute.
- `consume`  in  1  CPU accepts the head instruction this cycle.
- `cur_instr`  out  16  head instruction word; 0x0000 (NOP) when the queue is empty.
- `cur_op2`  out  16  second word of a two-word head instruction; 0 otherwise.
- `cur_pc`  out  PC_W  word address of `cur_instr`.
- `instr_valid`  out  1  head instruction is complete and may be consumed.
- `q_count`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Queue: circular buffer of {pc, word} entries with read pointer, write pointer and count.
- Enqueue: each cycle with no redirect, write {fpc, prog_data} and set fpc ← fpc+1, provided count < DEPTH or a pop happens in the same cycle.
- Pop: occurs on `consume` & `instr_valid`. `consume` while invalid is ignored: no pop and no error.
- Relative redirect (`pc_src`=1) requires `consume` in the same cycle. Target = cur_pc + 1 + jmp, truncated modulo 2^PC_W.
- Absolute redirect (`pc_src`=2): target = jmp[PC_W-1:0], zero-extended when PC_W > 16.
- Any redirect flushes the queue (count ← 0), loads fpc ← target, and clears skip_pend. There is no enqueue that cycle.
- Skip (`pc_src`=3, with `consume`):
  - The instruction following the consumed one is discarded.
  - If it is already queued, it is popped together with the head.
  - Otherwise skip_pend is set, and the next enqueued instruction is dropped instead of written; skip_pend then clears.
- Wrap: fpc and pointers wrap silently. Address 2^PC_W−1 is followed by 0.
- State summary: FILL (count < DEPTH), FULL (count = DEPTH, fetch stalls; fpc and prog_addr hold), FLUSH (one cycle after a redirect, count = 0).

## Timing
- Reset values: fpc=0, prog_addr=0, count=0, q_count=0, instr_valid=0, cur_instr=0x0000, cur_op2=0, cur_pc=0, skip_pend=0.
- Reset mid-operation discards all entries and any pending skip, regardless of the other inputs.
- After reset release at edge E:
  - edge E+1 enqueues word 0;
  - instr_valid=1 with cur_pc=0 one cycle after edge E+1.
- Redirect penalty is two cycles. With the redirect sampled at edge N:
  - prog_addr = target during cycle N+1;
  - instr_valid=1 with cur_pc = target after edge N+2.
- Steady state: one instruction per cycle with `consume` held high.
- Full with `consume`: one pop and one enqueue in the same edge; count is unchanged.
- Priority: `RST` > redirect > skip > normal pop/enqueue.

## Configuration
- `AVR_FETCH_WIDE_EN` defined:
  - The head is decoded for two-word opcodes: JMP/CALL (1001_010x_xxxx_11xx), LDS (1001_000x_xxxx_0000), STS (1001_001x_xxxx_0000).
  - For a two-word head, instr_valid asserts only when count ≥ 2. cur_op2 = the entry after the head, and a pop removes two entries.
  - Skip discards both words when the skipped instruction is two-word. A pending skip reads the first enqueued word and drops one or two words accordingly.
  - Relative base becomes cur_pc + 2 for a two-word head.
- Undefined: every word is treated as a one-word instruction, cur_op2 is tied to 0, and the decode logic is absent.

## Test plan
- Reset/fill: program words 0..7 = 0xE0A4, 0x50A1, …; assert RST for 2 cycles, then hold `consume`=0.
  - Expect prog_addr 0,1,2,3, then held at 4.
  - Expect q_count 1→4, instr_valid=1, cur_instr=0xE0A4, cur_pc=0.
- Streaming: `consume`=1 continuously from a full queue. Expect cur_pc 0,1,2,… on consecutive cycles and q_count steady at 4.
- Absolute jump: `pc_src`=2, `jmp`=0x0100 at cur_pc=3.
  - Expect q_count=0 and prog_addr=0x0100 next cycle.
  - Expect cur_pc=0x0100 with instr_valid two cycles after the redirect.
- Relative jump with wrap (PC_W=16): at cur_pc=0x0002, `pc_src`=1, `jmp`=0xFFF0. Expect new cur_pc=0xFFF3.
- Skip: first with the next instruction queued, then again with the queue empty (forcing a pending skip).
  - With `pc_src`=3 at cur_pc=5, expect next cur_pc=7.
  - With the queue empty, expect the dropped word never to appear at the head.
- Wide (macro on): program word 10 = 0x940C (JMP), word 11 = 0x0200.
  - Expect cur_instr=0x940C, cur_op2=0x0200, and cur_pc=12 after the pop.
  - Skip over it from word 9: expect next cur_pc=12.
